// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter
// Round-robin arbiter sharing one AHB-to-APB bridge slave port among
// NUM_MASTERS AHB masters. Grants are one-hot and registered. The
// address-phase mux follows the registered owner. The write-data mux follows
// the data-phase owner, so a handover never cuts off a data phase already in
// flight. Each owner gets a transfer quantum while others wait, and Hlock
// overrides that quantum.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int QUANTUM     = 4,
    localparam int MW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic [NUM_MASTERS-1:0]    Hbusreq,
    input  logic [NUM_MASTERS-1:0]    Hlock,
    input  logic [2*NUM_MASTERS-1:0]  Htrans_m,
    input  logic [32*NUM_MASTERS-1:0] Haddr_m,
    input  logic [NUM_MASTERS-1:0]    Hwrite_m,
    input  logic [32*NUM_MASTERS-1:0] Hwdata_m,
    input  logic                      Hreadyout,
    output logic [NUM_MASTERS-1:0]    Hgrant,
    output logic [MW-1:0]             Hmaster,
    output logic                      Hmastlock,
    output logic [1:0]                Htrans,
    output logic [31:0]               Haddr,
    output logic                      Hwrite,
    output logic [31:0]               Hwdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [3:0]    QUANT4   = 4'(QUANTUM);
    localparam logic [3:0]    QCNT_MAX = 4'd15;
    localparam logic [MW-1:0] LAST_IDX = MW'(NUM_MASTERS - 1);

    // Registered state
    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [MW-1:0]          r_hmaster;
    logic [MW-1:0]          r_hmaster_d;
    logic [MW-1:0]          r_ptr;
    logic [3:0]             r_qcnt;

    // Next-state values
    state_t                 w_state_nx;
    logic [NUM_MASTERS-1:0] w_hgrant_nx;
    logic [MW-1:0]          w_hmaster_nx;
    logic [MW-1:0]          w_hmaster_d_nx;
    logic [MW-1:0]          w_ptr_nx;
    logic [3:0]             w_qcnt_nx;

    // Helpers
    logic [1:0]             w_htrans_own;
    logic                   w_accept;
    logic [NUM_MASTERS-1:0] w_others;
    logic [MW:0]            w_pick_all;
    logic [MW:0]            w_pick_oth;
    logic [3:0]             w_qcnt_inc;

    // Round-robin scan starting at 'start'.
    // Result is {found, index}; the first set bit in scan order wins.
    function automatic logic [MW:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                           input logic [MW-1:0]          start);
        logic [MW:0]   res;
        logic [MW-1:0] w_idx;
        int            idx;
        res = '0;
        // Walk the scan order backwards so the earliest hit overwrites later ones.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx   = (int'(start) + i) % NUM_MASTERS;
            w_idx = idx[MW-1:0];
            if (req[w_idx]) begin
                res = {1'b1, w_idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Pointer value that follows a grant to 'w', wrapping at the last master.
    function automatic logic [MW-1:0] f_next_ptr(input logic [MW-1:0] w);
        logic [MW-1:0] res;
        if (w == LAST_IDX) begin
            res = '0;
        end else begin
            res = w + MW'(1);
        end
        return res;
    endfunction

    // One-hot grant vector for master 'w'.
    function automatic logic [NUM_MASTERS-1:0] f_onehot(input logic [MW-1:0] w);
        logic [NUM_MASTERS-1:0] res;
        res    = '0;
        res[w] = 1'b1;
        return res;
    endfunction

    // Transfer bookkeeping. A transfer is accepted when the bridge is ready
    // and the owner drives NONSEQ or SEQ. The HTRANS msb marks both of those.
    assign w_htrans_own = Htrans_m[{r_hmaster, 1'b0} +: 2];
    assign w_accept     = Hreadyout & (r_state == ST_OWN) & w_htrans_own[1];
    assign w_others     = Hbusreq & ~r_hgrant;
    assign w_pick_all   = f_pick(Hbusreq, r_ptr);
    assign w_pick_oth   = f_pick(w_others, r_ptr);
    assign w_qcnt_inc   = (r_qcnt == QCNT_MAX) ? QCNT_MAX : (r_qcnt + 4'd1);

    // Next-state decision. This logic is evaluated only on bridge-ready
    // edges; otherwise every register holds its value.
    always_comb begin
        w_state_nx     = r_state;
        w_hgrant_nx    = r_hgrant;
        w_hmaster_nx   = r_hmaster;
        w_hmaster_d_nx = r_hmaster_d;
        w_ptr_nx       = r_ptr;
        w_qcnt_nx      = r_qcnt;
        if (Hreadyout) begin
            w_hmaster_d_nx = r_hmaster;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_all[MW]) begin
                        w_state_nx   = ST_OWN;
                        w_hgrant_nx  = f_onehot(w_pick_all[MW-1:0]);
                        w_hmaster_nx = w_pick_all[MW-1:0];
                        w_ptr_nx     = f_next_ptr(w_pick_all[MW-1:0]);
                        w_qcnt_nx    = 4'd0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (Hlock[r_hmaster]) begin
                        // A locked sequence keeps the bus; the count still saturates.
                        if (w_accept) begin
                            w_qcnt_nx = w_qcnt_inc;
                        end else begin
                            w_qcnt_nx = r_qcnt;
                        end
                    end else if (!Hbusreq[r_hmaster]) begin
                        // The owner lets go; hand over in the same edge when possible.
                        if (w_pick_all[MW]) begin
                            w_hgrant_nx  = f_onehot(w_pick_all[MW-1:0]);
                            w_hmaster_nx = w_pick_all[MW-1:0];
                            w_ptr_nx     = f_next_ptr(w_pick_all[MW-1:0]);
                            w_qcnt_nx    = 4'd0;
                        end else begin
                            w_state_nx  = ST_IDLE;
                            w_hgrant_nx = '0;
                            w_qcnt_nx   = 4'd0;
                        end
                    end else if (w_accept && w_pick_oth[MW] && (w_qcnt_inc >= QUANT4)) begin
                        // The quantum is used up while others wait.
                        // The >= also covers a count that ran past the quantum
                        // while this master was alone or locked.
                        w_hgrant_nx  = f_onehot(w_pick_oth[MW-1:0]);
                        w_hmaster_nx = w_pick_oth[MW-1:0];
                        w_ptr_nx     = f_next_ptr(w_pick_oth[MW-1:0]);
                        w_qcnt_nx    = 4'd0;
                    end else if (w_accept) begin
                        w_qcnt_nx = w_qcnt_inc;
                    end else begin
                        w_qcnt_nx = r_qcnt;
                    end
                end
                default: begin
                    w_state_nx  = ST_IDLE;
                    w_hgrant_nx = '0;
                    w_qcnt_nx   = 4'd0;
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // Arbitration registers. Reset drops any grant immediately.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state     <= ST_IDLE;
            r_hgrant    <= '0;
            r_hmaster   <= '0;
            r_hmaster_d <= '0;
            r_ptr       <= '0;
            r_qcnt      <= 4'd0;
        end else begin
            r_state     <= w_state_nx;
            r_hgrant    <= w_hgrant_nx;
            r_hmaster   <= w_hmaster_nx;
            r_hmaster_d <= w_hmaster_d_nx;
            r_ptr       <= w_ptr_nx;
            r_qcnt      <= w_qcnt_nx;
        end
    end

    // Bridge-side muxes. Address-phase signals come from the registered owner
    // and are forced idle without a grant. Write data follows the data-phase
    // owner.
    assign Hgrant    = r_hgrant;
    assign Hmaster   = r_hmaster;
    assign Hmastlock = (r_state == ST_OWN) & Hlock[r_hmaster];
    assign Htrans    = (r_state == ST_OWN) ? w_htrans_own : 2'b00;
    assign Haddr     = (r_state == ST_OWN) ? Haddr_m[{r_hmaster, 5'b00000} +: 32] : 32'h0000_0000;
    assign Hwrite    = (r_state == ST_OWN) ? Hwrite_m[r_hmaster] : 1'b0;
    assign Hwdata    = Hwdata_m[{r_hmaster_d, 5'b00000} +: 32];

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter (4 masters, quantum 4).
module tb_ahb_bridge_arbiter;

    localparam int N = 4;
    localparam int Q = 4;

    logic            Hclk = 1'b0;
    logic            Hreset;
    logic [N-1:0]    Hbusreq, Hlock, Hwrite_m;
    logic [2*N-1:0]  Htrans_m;
    logic [32*N-1:0] Haddr_m, Hwdata_m;
    logic            Hreadyout;
    logic [N-1:0]    Hgrant;
    logic [1:0]      Hmaster;
    logic            Hmastlock;
    logic [1:0]      Htrans;
    logic [31:0]     Haddr, Hwdata;
    logic            Hwrite;

    int checks = 0;
    int errors = 0;

    ahb_bridge_arbiter #(.NUM_MASTERS(N), .QUANTUM(Q)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hbusreq(Hbusreq), .Hlock(Hlock),
        .Htrans_m(Htrans_m), .Haddr_m(Haddr_m), .Hwrite_m(Hwrite_m),
        .Hwdata_m(Hwdata_m), .Hreadyout(Hreadyout), .Hgrant(Hgrant),
        .Hmaster(Hmaster), .Hmastlock(Hmastlock), .Htrans(Htrans),
        .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The owner is tracked as an integer, with -1 meaning nobody holds the bus.
    int m_owner, m_hm, m_ptr, m_cnt, m_dm;

    function automatic int pick(input logic [N-1:0] req, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (req[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_hm = 0; m_ptr = 0; m_cnt = 0; m_dm = 0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w; m_hm = w; m_ptr = (w + 1) % N; m_cnt = 0;
    endtask

    // Apply one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit acc;
        int w;
        if (!Hreadyout) return;
        acc  = (m_owner >= 0) && Htrans_m[2*m_owner+1];
        m_dm = m_hm;
        if (m_owner < 0) begin
            w = pick(Hbusreq, m_ptr, -1);
            if (w >= 0) model_grant(w);
        end else if (Hlock[m_owner]) begin
            if (acc) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
        end else if (!Hbusreq[m_owner]) begin
            w = pick(Hbusreq, m_ptr, m_owner);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
        end else begin
            w = pick(Hbusreq, m_ptr, m_owner);
            if (acc && w >= 0 && m_cnt + 1 >= Q) model_grant(w);
            else if (acc) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk({tag, " grant"}, 32'(Hgrant), 32'(eg));
        chk({tag, " hmaster"}, 32'(Hmaster), 32'(m_hm));
        chk({tag, " mastlock"}, 32'(Hmastlock), (m_owner >= 0) ? 32'(Hlock[m_owner]) : 32'd0);
        chk({tag, " htrans"}, 32'(Htrans), (m_owner >= 0) ? 32'(Htrans_m[2*m_owner +: 2]) : 32'd0);
        chk({tag, " haddr"}, Haddr, (m_owner >= 0) ? Haddr_m[32*m_owner +: 32] : 32'd0);
        chk({tag, " hwrite"}, 32'(Hwrite), (m_owner >= 0) ? 32'(Hwrite_m[m_owner]) : 32'd0);
        chk({tag, " hwdata"}, Hwdata, Hwdata_m[32*m_dm +: 32]);
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic do_reset();
        Hreset = 1'b1;
        Hbusreq = '0; Hlock = '0; Hreadyout = 1'b1;
        tick();
        Hreset = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0100;
    endfunction

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic         rdy;
        logic [N-1:0] eg;
        logic [1:0]   ehm;
        logic         eml;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Directed vectors; they start from the state right after the reset test.
        tbl[0]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[2]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[3]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[4]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[5]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[6]  = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[10] = '{4'b0011, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[11] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};

        Htrans_m = 8'b10101010;
        Hwrite_m = 4'b0101;
        for (int i = 0; i < N; i++) begin
            Haddr_m[32*i +: 32]  = addr_of(i);
            Hwdata_m[32*i +: 32] = 32'hD000_0000 + 32'(i);
        end

        // Reset state, then an asynchronous reset in the middle of a grant.
        do_reset();
        chk("rst grant", 32'(Hgrant), 32'd0);
        chk("rst hmaster", 32'(Hmaster), 32'd0);
        chk("rst htrans", 32'(Htrans), 32'd0);
        Hbusreq = 4'b0010;
        tick();
        chk("pre-rst grant", 32'(Hgrant), 32'h2);
        #2;
        Hreset = 1'b1;
        #1;
        chk("async grant", 32'(Hgrant), 32'd0);
        chk("async hmaster", 32'(Hmaster), 32'd0);
        chk("async mastlock", 32'(Hmastlock), 32'd0);
        chk("async htrans", 32'(Htrans), 32'd0);
        chk("async haddr", Haddr, 32'd0);
        chk("async hwrite", 32'(Hwrite), 32'd0);
        chk("async hwdata", Hwdata, Hwdata_m[31:0]);
        Hreset = 1'b0;

        // Table-driven vectors.
        for (int k = 0; k < 12; k++) begin
            Hbusreq = tbl[k].req; Hlock = tbl[k].lock; Hreadyout = tbl[k].rdy;
            tick();
            chk($sformatf("tbl%0d grant", k), 32'(Hgrant), 32'(tbl[k].eg));
            chk($sformatf("tbl%0d hmaster", k), 32'(Hmaster), 32'(tbl[k].ehm));
            chk($sformatf("tbl%0d mastlock", k), 32'(Hmastlock), 32'(tbl[k].eml));
            chk($sformatf("tbl%0d htrans", k), 32'(Htrans), (tbl[k].eg != 0) ? 32'h2 : 32'h0);
            chk($sformatf("tbl%0d haddr", k), Haddr, (tbl[k].eg != 0) ? addr_of(int'(tbl[k].ehm)) : 32'h0);
        end

        // Round robin with every master requesting and issuing NONSEQ.
        do_reset();
        Hbusreq = 4'b1111;
        for (int e = 1; e <= 17; e++) begin
            tick();
            chk($sformatf("rr e%0d hmaster", e), 32'(Hmaster), 32'(((e - 1) / Q) % N));
            chk($sformatf("rr e%0d grant", e), 32'(Hgrant), 32'(N'(1) << (((e - 1) / Q) % N)));
        end

        // Hlock holds the bus beyond the quantum.
        do_reset();
        Hbusreq = 4'b0010;
        tick();
        Hbusreq = 4'b1111; Hlock = 4'b0010;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk($sformatf("lock e%0d grant", e), 32'(Hgrant), 32'h2);
            chk($sformatf("lock e%0d mastlock", e), 32'(Hmastlock), 32'd1);
        end
        Hbusreq = 4'b1101; Hlock = 4'b0000;
        tick();
        chk("unlock grant", 32'(Hgrant), 32'h4);
        chk("unlock hmaster", 32'(Hmaster), 32'd2);
        chk("unlock mastlock", 32'(Hmastlock), 32'd0);

        // Wait states during a master 0 write, then a handover to master 3.
        do_reset();
        Hbusreq = 4'b0001;
        tick();
        tick();
        Hbusreq = 4'b1001; Hreadyout = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk($sformatf("ws%0d grant", e), 32'(Hgrant), 32'h1);
            chk($sformatf("ws%0d hmaster", e), 32'(Hmaster), 32'd0);
            chk($sformatf("ws%0d hwdata", e), Hwdata, Hwdata_m[31:0]);
        end
        Hbusreq = 4'b1000; Hreadyout = 1'b1;
        tick();
        chk("ws handover grant", 32'(Hgrant), 32'h8);
        chk("ws handover hwdata", Hwdata, Hwdata_m[31:0]);
        tick();
        chk("ws after hwdata", Hwdata, Hwdata_m[127:96]);

        // Data-phase tracking across an immediate handover.
        do_reset();
        Hwdata_m[31:0]  = 32'hA5A5_0001;
        Hwdata_m[63:32] = 32'h5A5A_0002;
        Hwrite_m = 4'b0011;
        Hbusreq = 4'b0001;
        tick();
        Hbusreq = 4'b0010;
        tick();
        chk("dp first hwdata", Hwdata, 32'hA5A5_0001);
        chk("dp first hmaster", 32'(Hmaster), 32'd1);
        tick();
        chk("dp second hwdata", Hwdata, 32'h5A5A_0002);

        // Random traffic checked against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            Hbusreq   = N'($urandom);
            Hlock     = N'($urandom & $urandom & $urandom);
            Htrans_m  = (2*N)'($urandom);
            Hwrite_m  = N'($urandom);
            Hreadyout = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                Haddr_m[32*i +: 32]  = $urandom;
                Hwdata_m[32*i +: 32] = $urandom;
            end
            model_edge();
            tick();
            check_all($sformatf("rnd%0d", c));
            if ($urandom_range(0, 199) == 0) begin
                Hreset = 1'b1;
                #1;
                model_reset();
                check_all($sformatf("rnd%0d rst", c));
                Hreset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
